// File: rtl/dmem_bridge.sv
// dmem_bridge: LSU-to-data-memory bridge.
// Turns a level-held LSU load/store request into a single req/gnt/rvalid bus
// transaction with a word address and byte enables. Load data comes back
// shifted so the addressed byte/half sits in the low bits. The core is stalled
// until the access completes. Misaligned accesses and bus timeouts raise a
// one-cycle err pulse.
// Optional feature: define DMEM_BRIDGE_TIMEOUT_EN to build the bus timeout
// counter. Without it the bridge waits indefinitely for gnt/rvalid.
//
// state | meaning
// IDLE  | no access in flight, decode the LSU request
// REQ   | mem_req asserted, address/be/wdata/we held until mem_gnt
// RESP  | read granted, waiting for mem_rvalid
// DONE  | access complete, stall released for one cycle
// ERR   | misaligned access or timeout, err high and stall released for one cycle
module dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [1:0]  load_size,
  input  logic [1:0]  store_size,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic        req;
  logic [1:0]  req_size;
  logic [1:0]  off;
  logic [1:0]  off_q;
  logic        aligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic        tmo_hit;

  assign req   = read_en | write_en;
  assign stall = req & (state != S_DONE) & (state != S_ERR);

  // Decode alignment and store lane placement; a store outranks a load.
  always_comb begin
    req_size   = write_en ? store_size : load_size;
    off        = address[1:0];
    be_next    = 4'b1111;
    wdata_next = 32'h0;
    case (req_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b0;
    endcase
    if (write_en) begin
      case (store_size)
        2'b00: begin
          be_next    = 4'b0001 << off;
          wdata_next = {4{store_data[7:0]}};
        end
        2'b01: begin
          be_next    = 4'b0011 << off;
          wdata_next = {2{store_data[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = store_data;
        end
      endcase
    end
  end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic [15:0] tmo_next;

  assign tmo_next = tmo_cnt + 16'd1;
  assign tmo_hit  = (tmo_next >= 16'(TIMEOUT_CYCLES));

  // Count cycles spent on the bus; restart from zero whenever idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 16'd0;
    end else if (state == S_IDLE) begin
      tmo_cnt <= 16'd0;
    end else if ((state == S_REQ) || (state == S_RESP)) begin
      tmo_cnt <= tmo_next;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Transaction sequencer with registered bus and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      load_data <= 32'h0;
      err       <= 1'b0;
      off_q     <= 2'b00;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            if (aligned) begin
              mem_addr  <= {address[31:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
              mem_we    <= write_en;
              off_q     <= off;
              mem_req   <= 1'b1;
              state     <= S_REQ;
            end else begin
              err       <= 1'b1;
              load_data <= 32'h0;
              state     <= S_ERR;
            end
          end
        end
        S_REQ: begin
          // A grant on the same cycle as the timeout still completes the access.
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= mem_we ? S_DONE : S_RESP;
          end else if (tmo_hit) begin
            mem_req   <= 1'b0;
            err       <= 1'b1;
            load_data <= 32'h0;
            state     <= S_ERR;
          end
        end
        S_RESP: begin
          if (mem_rvalid) begin
            load_data <= mem_rdata >> {off_q, 3'b000};
            state     <= S_DONE;
          end else if (tmo_hit) begin
            err       <= 1'b1;
            load_data <= 32'h0;
            state     <= S_ERR;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
